// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI master and its sub-modules.
//   spi_state_t          - master FSM states (IDLE, SETUP, HIGH, LOW)
//   SPI_DEFAULT_WIDTH    - default bits per frame
//   SPI_DEFAULT_CLK_DIV  - default sclk half-period in clk cycles
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } spi_state_t;

    localparam int SPI_DEFAULT_WIDTH   = 8;
    localparam int SPI_DEFAULT_CLK_DIV = 4;

endpackage

// File: rtl/spi_master_if.sv
// spi_master_if: control-side handshake plus SPI pins of the master.
// Handshake: start is a request sampled only while the master is idle; the
// word on tx_data is captured on the edge that accepts start. busy is high
// from the cycle after acceptance until the frame ends, and done pulses for
// one cycle in the same cycle that rx_data takes the new received word.
//   start, tx_data   : requester -> master
//   miso             : slave     -> master
//   ss, sclk, mosi   : master    -> slave
//   rx_data, busy,
//   done             : master    -> requester
//   state            : master FSM state, for observation only
// Modports: master (the spi_master side) and slave (requester/pins side).
interface spi_master_if
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DEFAULT_WIDTH
);

    logic                  start;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  miso;
    logic                  ss;
    logic                  sclk;
    logic                  mosi;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  busy;
    logic                  done;
    spi_state_t            state;

    modport master (
        input  start, tx_data, miso,
        output ss, sclk, mosi, rx_data, busy, done, state
    );

    modport slave (
        output start, tx_data, miso,
        input  ss, sclk, mosi, rx_data, busy, done, state
    );

endinterface

// File: rtl/spi_clk_div.sv
// spi_clk_div: loadable half-period down-counter.
//   clk      in  system clock
//   reset    in  synchronous active-high reset
//   load_i   in  reload the counter with CLK_DIV-1 (asserted on state entry)
//   expire_o out high while the counter is at 0, i.e. the current state has
//                lasted CLK_DIV cycles and may exit on the next edge
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    output logic expire_o
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(CLK_DIV - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 (CPOL=0, CPHA=0) master.
//   clk    in  system clock, rising edge
//   reset  in  synchronous active-high reset
//   bus    spi_master_if.master: start/tx_data request, miso in,
//          ss/sclk/mosi out, rx_data/busy/done result, state (FSM observe)
// Parameters: DATA_WIDTH bits per frame, CLK_DIV sclk half-period (>=2),
// CNT_W bit-counter width (2**CNT_W > DATA_WIDTH).
// Build option: define SPI_MASTER_LSB_FIRST_EN for LSB-first shifting in both
// directions; default is MSB first. Frame timing is the same in both builds.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DEFAULT_WIDTH,
    parameter int CLK_DIV    = SPI_DEFAULT_CLK_DIV,
    parameter int CNT_W      = 4
) (
    input  logic          clk,
    input  logic          reset,
    spi_master_if.master  bus
);

    spi_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  ss_q, ss_d;
    logic                  sclk_q, sclk_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  expire;
    logic                  state_change;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;

    // Every state entry restarts the half-period timer.
    assign state_change = (state_d != state_q);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk      (clk),
        .reset    (reset),
        .load_i   (state_change),
        .expire_o (expire)
    );

    // mosi is taken straight from the outgoing end of the tx shift register,
    // so it is registered and changes only on load and on entry to LOW.
`ifdef SPI_MASTER_LSB_FIRST_EN
    assign tx_shift = {1'b0, tx_q[DATA_WIDTH-1:1]};
    assign rx_shift = {bus.miso, rx_q[DATA_WIDTH-1:1]};
    assign bus.mosi = tx_q[0];
`else
    assign tx_shift = {tx_q[DATA_WIDTH-2:0], 1'b0};
    assign rx_shift = {rx_q[DATA_WIDTH-2:0], bus.miso};
    assign bus.mosi = tx_q[DATA_WIDTH-1];
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SETUP;
            SETUP:   if (expire)    state_d = HIGH;
            HIGH:    if (expire)    state_d = LOW;
            LOW: begin
                if (expire) begin
                    state_d = (bit_cnt_q == CNT_W'(DATA_WIDTH)) ? IDLE : HIGH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic, evaluated on the transition being taken so
    // that every pin and status output comes out of a register.
    always_comb begin
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        bit_cnt_d = bit_cnt_q;
        ss_d      = (state_d == IDLE);
        sclk_d    = (state_d == HIGH);
        busy_d    = (state_d != IDLE);
        done_d    = 1'b0;

        if (state_q == IDLE && state_d == SETUP) begin
            tx_d      = bus.tx_data;
            bit_cnt_d = '0;
        end
        // Rising sclk: capture miso and count the bit.
        if (state_q != HIGH && state_d == HIGH) begin
            rx_d      = rx_shift;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        // Falling sclk: present the next bit for a full half-period.
        if (state_q == HIGH && state_d == LOW) begin
            tx_d = tx_shift;
        end
        if (state_q == LOW && state_d == IDLE) begin
            rx_data_d = rx_q;
            done_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            ss_q      <= 1'b1;
            sclk_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            bit_cnt_q <= bit_cnt_d;
            ss_q      <= ss_d;
            sclk_q    <= sclk_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.ss      = ss_q;
    assign bus.sclk    = sclk_q;
    assign bus.rx_data = rx_data_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: self-checking bench for spi_master at CLK_DIV=2.
// A monitor on the falling clk edge checks mosi bits, setup time, ss timing
// and done/rx_data against queues filled when each frame is requested.
module tb_spi_master;
    import spi_pkg::*;

    localparam int DW    = 8;
    localparam int H     = 2;
    localparam int FRAME = 17 * H;
`ifdef SPI_MASTER_LSB_FIRST_EN
    localparam int FIRST_IDX = 0;
    localparam int LAST_IDX  = DW - 1;
    localparam int STEP      = 1;
`else
    localparam int FIRST_IDX = DW - 1;
    localparam int LAST_IDX  = 0;
    localparam int STEP      = -1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master_if #(.DATA_WIDTH(DW)) bus ();

    spi_master #(.DATA_WIDTH(DW), .CLK_DIV(H), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];
    logic          mosi_exp_q[$];
    int            total = 0;
    int            bad = 0;
    int            done_count = 0;

    logic          loopback = 1'b1;
    logic [DW-1:0] slave_word = '0;
    int            idx = FIRST_IDX;

    logic mon_en = 1'b0;
    logic aborting = 1'b0;
    logic b2b_arm = 1'b0;
    logic b2b = 1'b0;
    logic sclk_prev = 1'b0;
    logic ss_prev = 1'b1;
    logic mosi_prev = 1'b0;
    logic done_prev = 1'b0;
    int   mosi_age = 0;
    int   t_fall = 0;
    int   t_rise = 0;

    assign bus.miso = loopback ? bus.mosi : slave_word[idx];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [DW-1:0] tx, input logic [DW-1:0] rx);
        exp_q.push_back(rx);
        for (int i = 0; i < DW; i++) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
            mosi_exp_q.push_back(tx[i]);
`else
            mosi_exp_q.push_back(tx[DW-1-i]);
`endif
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic [DW-1:0] tx, input logic lb, input logic [DW-1:0] sw);
        loopback    = lb;
        slave_word  = sw;
        push_frame(tx, lb ? tx : sw);
        bus.tx_data = tx;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.tx_data = DW'($urandom_range(0, 255));
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val("done_seen", (done_count >= target), 1);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.mosi !== mosi_prev) mosi_age = 1;
            else mosi_age++;

            // Model slave: MSB-ready while ss is high, advance on sclk fall.
            if (bus.ss) idx = FIRST_IDX;
            else if (sclk_prev && !bus.sclk && idx != LAST_IDX) idx = idx + STEP;

            if (!sclk_prev && bus.sclk) begin
                check_val("busy_in_frame", bus.busy, 1);
                check_val("mosi_q_nonempty", (mosi_exp_q.size() > 0), 1);
                if (mosi_exp_q.size() > 0) begin
                    check_val("mosi_bit", bus.mosi, mosi_exp_q.pop_front());
                    check_val("mosi_setup_ok", (mosi_age > H), 1);
                end
            end

            if (ss_prev && !bus.ss) begin
                if (b2b) begin
                    check_val("ss_gap", cyc - t_rise, 1);
                    b2b = 1'b0;
                end
                t_fall = cyc;
            end
            if (!ss_prev && bus.ss) begin
                t_rise = cyc;
                if (!aborting) check_val("ss_low_len", cyc - t_fall, FRAME);
            end

            if (bus.done) begin
                done_count++;
                check_val("done_pulse_width", done_prev, 0);
                check_val("busy_low_at_done", bus.busy, 0);
                check_val("done_latency", cyc - t_fall, FRAME);
                check_val("exp_q_nonempty", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check_val("rx_data", bus.rx_data, exp_q.pop_front());
                if (b2b_arm) begin
                    b2b     = 1'b1;
                    b2b_arm = 1'b0;
                end
            end
        end
        sclk_prev = bus.sclk;
        ss_prev   = bus.ss;
        mosi_prev = bus.mosi;
        done_prev = bus.done;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int n;
        bus.start   = 1'b0;
        bus.tx_data = '0;
        reset       = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_ss", bus.ss, 1);
        check_val("rst_sclk", bus.sclk, 0);
        check_val("rst_mosi", bus.mosi, 0);
        check_val("rst_rx_data", bus.rx_data, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_done", bus.done, 0);
        check_val("rst_state", bus.state, IDLE);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Loopback pattern 0xA5.
        send(8'hA5, 1'b1, 8'h00);
        wait_done(1, 200);

        // Model slave returns 0x3C while all ones are sent.
        repeat (3) @(negedge clk);
        send(8'hFF, 1'b0, 8'h3C);
        wait_done(2, 200);

        // start during a frame is ignored.
        repeat (3) @(negedge clk);
        send(8'h96, 1'b1, 8'h00);
        repeat (9) @(negedge clk);
        bus.tx_data = 8'h00;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        wait_done(3, 200);
        repeat (40) @(negedge clk);
        check_val("ignored_start_frames", done_count, 3);
        check_val("ignored_start_busy", bus.busy, 0);

        // start held high: two back-to-back frames.
        base        = done_count;
        loopback    = 1'b1;
        b2b_arm     = 1'b1;
        push_frame(8'hC3, 8'hC3);
        push_frame(8'hC3, 8'hC3);
        bus.tx_data = 8'hC3;
        bus.start   = 1'b1;
        wait_done(base + 1, 200);
        n = 0;
        while (!bus.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("b2b_restart", bus.busy, 1);
        bus.start = 1'b0;
        wait_done(base + 2, 200);
        repeat (40) @(negedge clk);
        check_val("b2b_frames", done_count, base + 2);

        // Reset in the middle of a frame.
        base = done_count;
        send(8'hE7, 1'b1, 8'h00);
        repeat (14) @(negedge clk);
        aborting = 1'b1;
        reset    = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        check_val("abort_ss", bus.ss, 1);
        check_val("abort_sclk", bus.sclk, 0);
        check_val("abort_mosi", bus.mosi, 0);
        check_val("abort_busy", bus.busy, 0);
        check_val("abort_done", bus.done, 0);
        check_val("abort_rx_data", bus.rx_data, 0);
        exp_q.delete();
        mosi_exp_q.delete();
        repeat (40) @(negedge clk);
        aborting = 1'b0;
        check_val("abort_no_done", done_count, base);
        send(8'h5A, 1'b1, 8'h00);
        wait_done(base + 1, 200);

        // Single set bit, then a few random loopback words.
        repeat (2) @(negedge clk);
        send(8'h01, 1'b1, 8'h00);
        wait_done(base + 2, 200);
        for (int i = 0; i < 3; i++) begin
            repeat (2) @(negedge clk);
            send(DW'($urandom_range(0, 255)), 1'b1, 8'h00);
            wait_done(base + 3 + i, 200);
        end

        repeat (5) @(negedge clk);
        check_val("exp_q_drained", exp_q.size(), 0);
        check_val("mosi_q_drained", mosi_exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
